screen_sequencer: RTL and testbench
===================================

// Module: screen_sequencer
// PURPOSE
//  Top-level VGA screen controller for Keyboard Battleship.
//  Owns the single 12-bit RGB output and chooses which screen source drives it: start, board or end screen.
//  Screen changes are driven by keyboard/game events and take effect only at frame boundaries, so the picture never tears.
//  Every screen change passes through a black hand-over blank, so the next player cannot see the opponent's board.
// PARAMETERS
//  H_VIS_MIN     144  first visible H count
//  H_VIS_MAX     783  last visible H count
//  V_VIS_MIN     35   first visible V count
//  V_VIS_MAX     514  last visible V count
//  H_LINE_END    799  last H count of a line
//  V_FRAME_END   524  last V count of a frame
//  BLANK_FRAMES  8    number of black frames per transition (1..255)
// PORTS
//  clk              in   1   pixel clock (25 MHz)
//  rst_n            in   1   synchronous reset, active-low
//  H_Counter_Value  in   16  current horizontal count from VGA timing
//  V_Counter_Value  in   16  current vertical count from VGA timing
//  start_req        in   1   1-clk pulse, Enter key
//  turn_done        in   1   1-clk pulse, current player fired
//  game_over        in   1   1-clk pulse, all ships of one side sunk
//  start_rgb        in   12  {R,G,B} from start-screen renderer
//  board_rgb        in   12  {R,G,B} from board renderer
//  end_rgb          in   12  {R,G,B} from end-screen renderer
//  Red              out  4   registered pixel red
//  Green            out  4   registered pixel green
//  Blue             out  4   registered pixel blue
//  screen_sel       out  2   current screen: 0=START 1=BOARD 2=END 3=BLANK
//  active_player    out  1   player whose turn it is (0/1)
//  frame_tick       out  1   1-clk pulse at H==H_LINE_END && V==V_FRAME_END
//  busy             out  1   high while in BLANK
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge)
//   - state=START, screen_sel=0, active_player=0, busy=0, frame_tick=0.
//   - RGB=0, blank counter=0, all pending flags cleared.
//   - Reset mid-blank or mid-game aborts the transition; no target is remembered.
//  Event capture
//   - Each request pulse sets a sticky pending flag.
//   - Flags are evaluated and cleared only on frame_tick.
//   - A pulse arriving in the same cycle as frame_tick is counted for that tick.
//   - Priority when several flags are set: game_over > turn_done > start_req.
//   - Flags not legal in the current state are dropped at the tick.
//  FSM (updates only on frame_tick)
//   - START: start_req -> BLANK, target=BOARD, active_player=0.
//   - BOARD: game_over -> BLANK, target=END (active_player kept; it names the winner).
//   - BOARD: turn_done -> BLANK, target=BOARD, active_player toggles when BLANK exits.
//   - END: start_req -> BLANK, target=START.
//   - BLANK: counter counts frame_ticks; at BLANK_FRAMES state=target and counter=0.
//   - BLANK: all requests are ignored and their flags cleared.
//   - screen_sel and busy change on the same clk edge as the state.
//  Pixel path (1 clk latency)
//   - RGB registered from the source selected by the current screen_sel.
//   - Source inputs must be aligned to the H/V counts sampled in the same cycle.
//   - Outside H_VIS_MIN..H_VIS_MAX x V_VIS_MIN..V_VIS_MAX, and whenever in BLANK, RGB=0.
//   - Comparisons are inclusive and on the full 16-bit counts; no wrap handling is needed (the counts are bounded).
// STRUCTURE
//  Shared include vga_defs.vh:
//   - visible/line/frame bound constants.
//   - screen encodings SCR_START/SCR_BOARD/SCR_END/SCR_BLANK.
//   - state encodings.
//  Sub-module vga_frame_tick:
//   - H/V compare producing frame_tick and in_visible.
//   - reused by the board renderer.
//  Rest in this file: pending flags, FSM, blank counter, RGB mux register.
// TESTING
//  1. Reset, then start_req at V=100.
//     - Stays START until frame_tick; then BLANK for 8 ticks, then BOARD.
//     - active_player=0; RGB=0x000 throughout BLANK.
//  2. In BOARD with player 0, turn_done.
//     - BLANK for 8 frames, then BOARD with active_player=1.
//     - A second turn_done -> active_player=0.
//  3. In BOARD, game_over and turn_done in the same frame.
//     - Takes the END path; active_player unchanged; turn_done dropped.
//  4. Pixel path in START with start_rgb=0xDDD.
//     - H=144,V=35 -> 0xDDD one clk later.
//     - H=143 or H=784 or V=515 -> 0x000.
//  5. Assert rst_n=0 for 1 clk during the 4th BLANK frame.
//     - START next cycle, busy=0.
//     - Pending flags cleared; start_req still needed to leave START.
//  6. start_req pulsed while in BOARD or in BLANK.
//     - No state change; the flag is gone after the next frame_tick.

Source files
------------

// File: rtl/screen_sequencer_pkg.sv
// Shared definitions for the Battleship screen sequencer: VGA bounds, screen/state
// encodings and the request-flag record.
package screen_sequencer_pkg;

    localparam logic [15:0] H_VIS_MIN_DEF   = 16'd144;
    localparam logic [15:0] H_VIS_MAX_DEF   = 16'd783;
    localparam logic [15:0] V_VIS_MIN_DEF   = 16'd35;
    localparam logic [15:0] V_VIS_MAX_DEF   = 16'd514;
    localparam logic [15:0] H_LINE_END_DEF  = 16'd799;
    localparam logic [15:0] V_FRAME_END_DEF = 16'd524;
    localparam int unsigned BLANK_FRAMES_DEF = 8;

    localparam logic [1:0] SCR_START = 2'd0;
    localparam logic [1:0] SCR_BOARD = 2'd1;
    localparam logic [1:0] SCR_END   = 2'd2;
    localparam logic [1:0] SCR_BLANK = 2'd3;

    // State encoding equals the screen encoding so screen_sel is the state itself.
    typedef enum logic [1:0] {
        ST_START = SCR_START,
        ST_BOARD = SCR_BOARD,
        ST_END   = SCR_END,
        ST_BLANK = SCR_BLANK
    } state_e;

    typedef struct packed {
        logic game_over;
        logic turn_done;
        logic start_req;
    } req_t;

    function automatic logic in_span(input logic [15:0] x,
                                     input logic [15:0] lo,
                                     input logic [15:0] hi);
        return (x >= lo) && (x <= hi);
    endfunction

endpackage

// File: rtl/screen_sequencer_frame_tick.sv
// Combinational H/V decode: end-of-frame strobe and visible-area flag.
// Shared with the board renderer so both agree on the same window.
module vga_frame_tick
    import screen_sequencer_pkg::*;
#(
    parameter logic [15:0] H_VIS_MIN   = H_VIS_MIN_DEF,
    parameter logic [15:0] H_VIS_MAX   = H_VIS_MAX_DEF,
    parameter logic [15:0] V_VIS_MIN   = V_VIS_MIN_DEF,
    parameter logic [15:0] V_VIS_MAX   = V_VIS_MAX_DEF,
    parameter logic [15:0] H_LINE_END  = H_LINE_END_DEF,
    parameter logic [15:0] V_FRAME_END = V_FRAME_END_DEF
) (
    input  logic [15:0] h_count_i,
    input  logic [15:0] v_count_i,
    output logic        frame_tick_o,
    output logic        in_visible_o
);

    assign frame_tick_o = (h_count_i == H_LINE_END) && (v_count_i == V_FRAME_END);
    assign in_visible_o = in_span(h_count_i, H_VIS_MIN, H_VIS_MAX)
                       && in_span(v_count_i, V_VIS_MIN, V_VIS_MAX);

endmodule

// File: rtl/screen_sequencer.sv
// Screen controller: latches key/game events, switches screens only at frame
// boundaries through a black hand-over blank, and registers the 12-bit pixel.
module screen_sequencer
    import screen_sequencer_pkg::*;
#(
    parameter logic [15:0] H_VIS_MIN    = H_VIS_MIN_DEF,
    parameter logic [15:0] H_VIS_MAX    = H_VIS_MAX_DEF,
    parameter logic [15:0] V_VIS_MIN    = V_VIS_MIN_DEF,
    parameter logic [15:0] V_VIS_MAX    = V_VIS_MAX_DEF,
    parameter logic [15:0] H_LINE_END   = H_LINE_END_DEF,
    parameter logic [15:0] V_FRAME_END  = V_FRAME_END_DEF,
    parameter int unsigned BLANK_FRAMES = BLANK_FRAMES_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] H_Counter_Value,
    input  logic [15:0] V_Counter_Value,
    input  logic        start_req,
    input  logic        turn_done,
    input  logic        game_over,
    input  logic [11:0] start_rgb,
    input  logic [11:0] board_rgb,
    input  logic [11:0] end_rgb,
    output logic [3:0]  Red,
    output logic [3:0]  Green,
    output logic [3:0]  Blue,
    output logic [1:0]  screen_sel,
    output logic        active_player,
    output logic        frame_tick,
    output logic        busy
);

    localparam logic [7:0] BLANK_LAST = 8'(BLANK_FRAMES - 1);

    logic        tick_raw;
    logic        in_visible;

    state_e      state_q,  state_d;
    state_e      target_q, target_d;
    logic        player_q, player_d;
    logic        flip_q,   flip_d;
    logic [7:0]  cnt_q,    cnt_d;
    req_t        pend_q,   pend_d;
    req_t        req_now;
    req_t        req_eff;
    logic [11:0] rgb_q,    rgb_d;
    logic [11:0] src_rgb;

    vga_frame_tick #(
        .H_VIS_MIN   (H_VIS_MIN),
        .H_VIS_MAX   (H_VIS_MAX),
        .V_VIS_MIN   (V_VIS_MIN),
        .V_VIS_MAX   (V_VIS_MAX),
        .H_LINE_END  (H_LINE_END),
        .V_FRAME_END (V_FRAME_END)
    ) u_frame_tick (
        .h_count_i    (H_Counter_Value),
        .v_count_i    (V_Counter_Value),
        .frame_tick_o (tick_raw),
        .in_visible_o (in_visible)
    );

    assign frame_tick = tick_raw & rst_n;

    // A pulse coinciding with the tick is folded in so it counts for that tick.
    assign req_now = '{game_over: game_over, turn_done: turn_done, start_req: start_req};
    assign req_eff = req_t'(pend_q | req_now);

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        player_d = player_q;
        flip_d   = flip_q;
        cnt_d    = cnt_q;
        pend_d   = req_eff;
        if (frame_tick) begin
            pend_d = '0;
            case (state_q)
                ST_START: begin
                    if (req_eff.start_req) begin
                        state_d  = ST_BLANK;
                        target_d = ST_BOARD;
                        player_d = 1'b0;
                        flip_d   = 1'b0;
                        cnt_d    = '0;
                    end
                end
                ST_BOARD: begin
                    if (req_eff.game_over) begin
                        state_d  = ST_BLANK;
                        target_d = ST_END;
                        flip_d   = 1'b0;
                        cnt_d    = '0;
                    end else if (req_eff.turn_done) begin
                        state_d  = ST_BLANK;
                        target_d = ST_BOARD;
                        flip_d   = 1'b1;
                        cnt_d    = '0;
                    end
                end
                ST_END: begin
                    if (req_eff.start_req) begin
                        state_d  = ST_BLANK;
                        target_d = ST_START;
                        flip_d   = 1'b0;
                        cnt_d    = '0;
                    end
                end
                default: begin
                    // Player hand-over happens on leaving the blank, never before.
                    if (cnt_q == BLANK_LAST) begin
                        state_d = target_q;
                        cnt_d   = '0;
                        flip_d  = 1'b0;
                        if (flip_q) begin
                            player_d = ~player_q;
                        end
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        case (state_q)
            ST_START: src_rgb = start_rgb;
            ST_BOARD: src_rgb = board_rgb;
            ST_END:   src_rgb = end_rgb;
            default:  src_rgb = '0;
        endcase
        rgb_d = (in_visible && (state_q != ST_BLANK)) ? src_rgb : 12'h000;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_START;
            target_q <= ST_START;
            player_q <= 1'b0;
            flip_q   <= 1'b0;
            cnt_q    <= '0;
            pend_q   <= '0;
            rgb_q    <= '0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            player_q <= player_d;
            flip_q   <= flip_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            rgb_q    <= rgb_d;
        end
    end

    assign screen_sel    = state_q;
    assign busy          = (state_q == ST_BLANK);
    assign active_player = player_q;

    logic [3:0] chan [3];
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_chan
            assign chan[gi] = rgb_q[11 - 4*gi -: 4];
        end
    endgenerate

    assign Red   = chan[0];
    assign Green = chan[1];
    assign Blue  = chan[2];

endmodule

// File: tb/tb_screen_sequencer.sv
// Self-checking bench for screen_sequencer: pixel-window table, hand-written
// screen-flow sequences and a randomized run against a rule-level model.
module tb_screen_sequencer;

    localparam int BLANK_FRAMES = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] h_cnt, v_cnt;
    logic        start_req, turn_done, game_over;
    logic [11:0] start_rgb, board_rgb, end_rgb;
    logic [3:0]  Red, Green, Blue;
    logic [1:0]  screen_sel;
    logic        active_player, frame_tick, busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    screen_sequencer dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .H_Counter_Value (h_cnt),
        .V_Counter_Value (v_cnt),
        .start_req       (start_req),
        .turn_done       (turn_done),
        .game_over       (game_over),
        .start_rgb       (start_rgb),
        .board_rgb       (board_rgb),
        .end_rgb         (end_rgb),
        .Red             (Red),
        .Green           (Green),
        .Blue            (Blue),
        .screen_sel      (screen_sel),
        .active_player   (active_player),
        .frame_tick      (frame_tick),
        .busy            (busy)
    );

    // Reference model: screen 0=START 1=BOARD 2=END 3=BLANK
    int m_scr, m_target, m_left;
    bit m_player, m_flip;
    bit p_sr, p_td, p_go;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_scr = 0; m_target = 0; m_left = 0; m_player = 0; m_flip = 0;
        p_sr = 0; p_td = 0; p_go = 0;
    endtask

    task automatic model_edge(input bit tick, input bit sr, input bit td, input bit go);
        bit e_sr, e_td, e_go;
        e_sr = p_sr | sr; e_td = p_td | td; e_go = p_go | go;
        if (!tick) begin
            p_sr = e_sr; p_td = e_td; p_go = e_go;
            return;
        end
        p_sr = 0; p_td = 0; p_go = 0;
        if (m_scr == 3) begin
            m_left--;
            if (m_left == 0) begin
                m_scr = m_target;
                if (m_flip) m_player = !m_player;
                m_flip = 0;
            end
        end else if (m_scr == 0 && e_sr) begin
            m_scr = 3; m_target = 1; m_player = 0; m_flip = 0; m_left = BLANK_FRAMES;
        end else if (m_scr == 1 && e_go) begin
            m_scr = 3; m_target = 2; m_flip = 0; m_left = BLANK_FRAMES;
        end else if (m_scr == 1 && e_td) begin
            m_scr = 3; m_target = 1; m_flip = 1; m_left = BLANK_FRAMES;
        end else if (m_scr == 2 && e_sr) begin
            m_scr = 3; m_target = 0; m_flip = 0; m_left = BLANK_FRAMES;
        end
    endtask

    function automatic logic [11:0] exp_pixel(input logic [15:0] h, input logic [15:0] v);
        bit vis;
        vis = (h >= 144 && h <= 783 && v >= 35 && v <= 514);
        if (!rst_n || !vis || m_scr == 3) return 12'h000;
        case (m_scr)
            0: return start_rgb;
            1: return board_rgb;
            default: return end_rgb;
        endcase
    endfunction

    // One clock: apply inputs, check the combinational tick, clock, compare registered outputs.
    task automatic cyc(input logic [15:0] h, input logic [15:0] v,
                       input bit sr, input bit td, input bit go);
        logic [11:0] e_rgb;
        bit e_tick;
        h_cnt = h; v_cnt = v; start_req = sr; turn_done = td; game_over = go;
        #1;
        e_tick = rst_n && (h == 16'd799) && (v == 16'd524);
        check("frame_tick", 32'(frame_tick), 32'(e_tick));
        e_rgb = exp_pixel(h, v);
        @(posedge clk);
        #1;
        if (!rst_n) model_reset();
        else model_edge(e_tick, sr, td, go);
        check("screen_sel", 32'(screen_sel), 32'(m_scr));
        check("active_player", 32'(active_player), 32'(m_player));
        check("busy", 32'(busy), 32'(m_scr == 3));
        check("rgb", 32'({Red, Green, Blue}), 32'(e_rgb));
        $display("t=%0t h=%0d v=%0d req=%b%b%b scr=%0d pl=%0d rgb=%03h",
                 $time, h, v, go, td, sr, screen_sel, active_player, {Red, Green, Blue});
        start_req = 0; turn_done = 0; game_over = 0;
    endtask

    // A short frame: pulses on the first visible cycle, two more visible cycles, then the tick.
    task automatic frame(input bit sr, input bit td, input bit go);
        cyc(16'd300, 16'd100, sr, td, go);
        cyc(16'd144, 16'd35, 0, 0, 0);
        cyc(16'd783, 16'd514, 0, 0, 0);
        cyc(16'd799, 16'd524, 0, 0, 0);
    endtask

    task automatic blank_run(input int n);
        for (int i = 0; i < n; i++) frame(0, 0, 0);
    endtask

    typedef struct {
        logic [15:0] h;
        logic [15:0] v;
        logic [11:0] exp;
    } pix_vec_t;

    pix_vec_t pix_tab [8];

    initial begin
        pix_tab[0] = '{16'd144, 16'd35,  12'hDDD};
        pix_tab[1] = '{16'd143, 16'd35,  12'h000};
        pix_tab[2] = '{16'd784, 16'd35,  12'h000};
        pix_tab[3] = '{16'd144, 16'd515, 12'h000};
        pix_tab[4] = '{16'd783, 16'd514, 12'hDDD};
        pix_tab[5] = '{16'd144, 16'd34,  12'h000};
        pix_tab[6] = '{16'd500, 16'd300, 12'hDDD};
        pix_tab[7] = '{16'd0,   16'd0,   12'h000};

        rst_n = 0; h_cnt = 0; v_cnt = 0;
        start_req = 0; turn_done = 0; game_over = 0;
        start_rgb = 12'hDDD; board_rgb = 12'h5A3; end_rgb = 12'hF0F;
        model_reset();
        cyc(16'd0, 16'd0, 0, 0, 0);
        cyc(16'd799, 16'd524, 1, 0, 0);
        check("reset_scr", 32'(screen_sel), 32'd0);
        check("reset_rgb", 32'({Red, Green, Blue}), 32'h000);
        rst_n = 1;

        // Pixel window in START
        for (int i = 0; i < 8; i++) begin
            cyc(pix_tab[i].h, pix_tab[i].v, 0, 0, 0);
            check("pix_tab", 32'({Red, Green, Blue}), 32'(pix_tab[i].exp));
        end

        // Start request waits for the tick, then 8 blank frames to BOARD
        cyc(16'd300, 16'd100, 1, 0, 0);
        cyc(16'd400, 16'd200, 0, 0, 0);
        check("t1_wait", 32'(screen_sel), 32'd0);
        cyc(16'd799, 16'd524, 0, 0, 0);
        check("t1_blank", 32'(screen_sel), 32'd3);
        blank_run(BLANK_FRAMES - 1);
        check("t1_still_blank", 32'(busy), 32'd1);
        frame(0, 0, 0);
        check("t1_board", 32'(screen_sel), 32'd1);
        check("t1_player", 32'(active_player), 32'd0);

        // Turn hand-over, twice
        frame(0, 1, 0);
        blank_run(BLANK_FRAMES);
        check("t2_player1", 32'(active_player), 32'd1);
        frame(0, 1, 0);
        blank_run(BLANK_FRAMES);
        check("t2_player0", 32'(active_player), 32'd0);
        frame(0, 1, 0);
        blank_run(BLANK_FRAMES);

        // game_over beats turn_done in the same frame
        cyc(16'd200, 16'd50, 0, 1, 0);
        cyc(16'd200, 16'd60, 0, 0, 1);
        cyc(16'd799, 16'd524, 0, 0, 0);
        blank_run(BLANK_FRAMES);
        check("t3_end", 32'(screen_sel), 32'd2);
        check("t3_winner", 32'(active_player), 32'd1);

        // END -> START, then START -> BOARD
        frame(1, 0, 0);
        blank_run(BLANK_FRAMES);
        check("end_to_start", 32'(screen_sel), 32'd0);
        frame(1, 0, 0);
        blank_run(BLANK_FRAMES);

        // start_req ignored in BOARD and in BLANK
        frame(1, 0, 0);
        check("t6_board_keep", 32'(screen_sel), 32'd1);
        frame(0, 0, 0);
        check("t6_board_keep2", 32'(screen_sel), 32'd1);
        frame(0, 1, 0);
        frame(1, 0, 0);
        blank_run(BLANK_FRAMES - 1);
        check("t6_after_blank", 32'(screen_sel), 32'd1);
        frame(0, 0, 0);
        check("t6_board", 32'(screen_sel), 32'd1);

        // Reset in the 4th blank frame aborts the transition
        frame(0, 1, 0);
        blank_run(3);
        cyc(16'd300, 16'd100, 1, 0, 0);
        rst_n = 0;
        cyc(16'd300, 16'd101, 0, 0, 0);
        rst_n = 1;
        check("t5_start", 32'(screen_sel), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        frame(0, 0, 0);
        check("t5_stay_start", 32'(screen_sel), 32'd0);

        // Randomized run
        for (int n = 0; n < 3000; n++) begin
            int unsigned r;
            logic [15:0] h, v;
            r = $urandom_range(0, 9);
            if (r < 2) begin
                h = 16'd799; v = 16'd524;
            end else if (r < 7) begin
                h = 16'($urandom_range(144, 783)); v = 16'($urandom_range(35, 514));
            end else begin
                h = 16'($urandom_range(0, 900)); v = 16'($urandom_range(0, 600));
            end
            start_rgb = 12'($urandom); board_rgb = 12'($urandom); end_rgb = 12'($urandom);
            rst_n = ($urandom_range(0, 199) != 0);
            cyc(h, v, $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                $urandom_range(0, 11) == 0);
        end
        rst_n = 1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
